timestamp_capture: RTL and testbench

TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

---
 rtl/timestamp_capture_pkg.sv | 9 +
 rtl/timestamp_capture_fifo.sv | 76 +++++++
 rtl/timestamp_capture.sv | 72 +++++++
 tb/tb_timestamp_capture.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/timestamp_capture_pkg.sv
// Shared constants and types for the timestamp capture block.
package timestamp_capture_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultDepth = 4;

    typedef logic [DefaultWidth-1:0] timestamp_t;

endpackage

// File: rtl/timestamp_capture_fifo.sv
// Capture FIFO: storage, wrapping pointers and occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module timestamp_fifo
    import timestamp_capture_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (level_q == LvlW'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_data  = mem[rd_ptr_q];

    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; level and pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/timestamp_capture.sv
// Captures the upstream counter value on each rising edge of i_event into a FIFO,
// with a sticky overflow flag for dropped captures.
module timestamp_capture
    import timestamp_capture_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [WIDTH-1:0]           i_count,
    input  logic                       i_event,
    input  logic                       i_ready,
    input  logic                       i_clear_overflow,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_timestamp,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_overflow
);

    logic event_q;
    logic overflow_q, overflow_d;
    logic capture;
    logic pop;
    logic full;
    logic empty;
    logic drop;

    assign capture = i_event & ~event_q;
    assign o_valid = ~empty;
    assign pop     = o_valid & i_ready;
    assign drop    = capture & full & ~pop;

    // Drop wins over a coincident clear so no lost capture goes unreported.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (i_clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Edge-detect and overflow registers; event_q resets high so a held event is ignored.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            event_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            event_q    <= i_event;
            overflow_q <= overflow_d;
        end
    end

    assign o_overflow = overflow_q;

    timestamp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (capture),
        .i_data    (i_count),
        .i_pop     (pop),
        .o_data    (o_timestamp),
        .o_full    (full),
        .o_empty   (empty),
        .o_level   (o_level)
    );

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed bench for timestamp_capture with hand-computed expectations.
module tb_timestamp_capture;
    import timestamp_capture_pkg::*;

    logic       i_clk;
    logic       i_reset_n;
    timestamp_t i_count;
    logic       i_event;
    logic       i_ready;
    logic       i_clear_overflow;
    logic       o_valid;
    timestamp_t o_timestamp;
    logic [2:0] o_level;
    logic       o_overflow;

    int num_cmp = 0;
    int num_err = 0;

    timestamp_capture #(
        .DEPTH (4),
        .WIDTH (16)
    ) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_count          (i_count),
        .i_event          (i_event),
        .i_ready          (i_ready),
        .i_clear_overflow (i_clear_overflow),
        .o_valid          (o_valid),
        .o_timestamp      (o_timestamp),
        .o_level          (o_level),
        .o_overflow       (o_overflow)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_cmp++;
        if (got !== exp) begin
            num_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs set beforehand are sampled at this edge; counter then advances.
    task automatic cyc();
        @(posedge i_clk);
        #1;
        i_count = i_count + 16'd1;
    endtask

    task automatic pulse_at(input logic [15:0] value);
        i_count = value;
        i_event = 1'b1;
        cyc();
        i_event = 1'b0;
        cyc();
    endtask

    logic [15:0] exp_q [4];

    initial begin
        i_reset_n        = 1'b0;
        i_count          = 16'h0010;
        i_event          = 1'b0;
        i_ready          = 1'b1;
        i_clear_overflow = 1'b0;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_level", o_level, 0);
        check("rst_ovf", o_overflow, 0);
        cyc();
        i_reset_n = 1'b1;

        // Single capture with ready high
        for (int i = 0; i < 64 && i_count != 16'h0025; i++) cyc();
        i_event = 1'b1;
        cyc();
        check("single_valid", o_valid, 1);
        check("single_ts", o_timestamp, 16'h0025);
        check("single_level1", o_level, 1);
        i_event = 1'b0;
        cyc();
        check("single_level0", o_level, 0);
        check("single_valid0", o_valid, 0);

        // Fill with ready low, then overflow
        i_ready = 1'b0;
        pulse_at(16'h0100);
        pulse_at(16'h0110);
        pulse_at(16'h0120);
        pulse_at(16'h0130);
        check("full_level", o_level, 4);
        check("full_ovf0", o_overflow, 0);
        check("full_head", o_timestamp, 16'h0100);
        pulse_at(16'h0140);
        check("drop_level", o_level, 4);
        check("drop_ovf", o_overflow, 1);
        check("drop_head", o_timestamp, 16'h0100);

        // Clear coincident with a drop: drop wins
        i_count          = 16'h0150;
        i_event          = 1'b1;
        i_clear_overflow = 1'b1;
        cyc();
        check("clr_drop_ovf", o_overflow, 1);
        check("clr_drop_level", o_level, 4);
        i_event = 1'b0;
        cyc();
        check("clr_ovf", o_overflow, 0);
        i_clear_overflow = 1'b0;

        // Push and pop together while full
        i_count = 16'h0160;
        i_event = 1'b1;
        i_ready = 1'b1;
        cyc();
        check("pp_level", o_level, 4);
        check("pp_ovf", o_overflow, 0);
        check("pp_head", o_timestamp, 16'h0110);
        i_event = 1'b0;
        exp_q[0] = 16'h0110;
        exp_q[1] = 16'h0120;
        exp_q[2] = 16'h0130;
        exp_q[3] = 16'h0160;
        for (int i = 0; i < 4; i++) begin
            check("drain_ts", o_timestamp, {16'h0, exp_q[i]});
            check("drain_level", o_level, 4 - i);
            cyc();
        end
        check("drain_empty", o_level, 0);

        // Event high out of reset: no capture until it first goes low
        i_ready   = 1'b0;
        i_reset_n = 1'b0;
        i_event   = 1'b1;
        cyc();
        i_count   = 16'h0000;
        i_reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] sampled;
            sampled = i_count;
            i_event = (sampled < 16'd5) || (sampled >= 16'd8);
            cyc();
            check("hold_level", o_level, (sampled >= 16'd8) ? 1 : 0);
        end
        check("hold_ts", o_timestamp, 16'h0008);

        // Three queued entries, then asynchronous reset mid-cycle
        i_event = 1'b0;
        cyc();
        pulse_at(16'h0200);
        pulse_at(16'h0210);
        check("q3_level", o_level, 3);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_level", o_level, 0);
        check("arst_ovf", o_overflow, 0);
        cyc();
        i_reset_n = 1'b1;
        cyc();
        cyc();
        check("post_valid", o_valid, 0);
        check("post_level", o_level, 0);
        pulse_at(16'h0300);
        check("post_level1", o_level, 1);
        check("post_ts", o_timestamp, 16'h0300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
        $finish;
    end

endmodule
